// File: rtl/tata_dmrf_pkg.sv
// Shared types for the dmrf operand controllers: load/exec FSM states and the latched exec command.
package tata_dmrf_pkg;

  localparam int unsigned DMRFY_EX_ADDR_W = 5;
  localparam int unsigned DMRFY_REPEAT_W  = 8;

  typedef enum logic {
    L_IDLE,
    L_ACTIVE
  } ld_state_e;

  typedef enum logic [1:0] {
    E_IDLE,
    E_WAIT,
    E_RUN
  } ex_state_e;

  typedef struct packed {
    logic [DMRFY_EX_ADDR_W-1:0] depth;
    logic [DMRFY_REPEAT_W-1:0]  reps;
  } dmrfy_ex_cmd_t;

endpackage

// File: rtl/dmrfy_int8_pingpong_ctrl_if.sv
// Command, dmrf_y and TAPU-facing signals of the INT8 y-operand ping-pong controller.
interface dmrfy_int8_pingpong_ctrl_if #(
  parameter int unsigned LOAD_ADDR_WIDTH = 5,
  parameter int unsigned EXEC_ADDR_WIDTH = 5,
  parameter int unsigned REPEAT_WIDTH    = 8
);
  logic                       ld_cmd_valid;
  logic                       ld_cmd_ready;
  logic [LOAD_ADDR_WIDTH-1:0] ld_cmd_depth;
  logic [LOAD_ADDR_WIDTH-1:0] dmrfy_load_depth;
  logic                       dmrfy_load_tile_sel;
  logic                       dmrfy_load_active;
  logic                       dmrfy_load_done;
  logic                       ex_cmd_valid;
  logic                       ex_cmd_ready;
  logic [EXEC_ADDR_WIDTH-1:0] ex_cmd_depth;
  logic [REPEAT_WIDTH-1:0]    ex_cmd_repeat;
  logic [EXEC_ADDR_WIDTH-1:0] dmrfy_exec_addr;
  logic                       dmrfy_exec_tile_sel;
  logic                       exec_valid;
  logic                       exec_ready;
  logic                       exec_data_valid;
  logic                       exec_data_last;
  logic [1:0]                 tile_full;
  logic                       err_spurious_done;

  modport master (
    output ld_cmd_valid, ld_cmd_depth, dmrfy_load_done, ex_cmd_valid, ex_cmd_depth,
           ex_cmd_repeat, exec_ready,
    input  ld_cmd_ready, dmrfy_load_depth, dmrfy_load_tile_sel, dmrfy_load_active,
           ex_cmd_ready, dmrfy_exec_addr, dmrfy_exec_tile_sel, exec_valid, exec_data_valid,
           exec_data_last, tile_full, err_spurious_done
  );

  modport slave (
    input  ld_cmd_valid, ld_cmd_depth, dmrfy_load_done, ex_cmd_valid, ex_cmd_depth,
           ex_cmd_repeat, exec_ready,
    output ld_cmd_ready, dmrfy_load_depth, dmrfy_load_tile_sel, dmrfy_load_active,
           ex_cmd_ready, dmrfy_exec_addr, dmrfy_exec_tile_sel, exec_valid, exec_data_valid,
           exec_data_last, tile_full, err_spurious_done
  );
endinterface

// File: rtl/fixed_lat_pipe.sv
// Fixed-latency shift register; not stallable, so downstream must sink at a fixed delay.
module fixed_lat_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dmrfy_int8_pingpong_ctrl.sv
// INT8 double-buffer scheduler for dmrf_y: loads one tile while the other is swept for execution.
module dmrfy_int8_pingpong_ctrl
  import tata_dmrf_pkg::*;
#(
  parameter int unsigned LOAD_ADDR_WIDTH = 5,
  parameter int unsigned EXEC_ADDR_WIDTH = 5,
  parameter int unsigned REPEAT_WIDTH    = 8,
  parameter int unsigned EXEC_PIPE_LAT   = 2
) (
  input logic                      clk,
  input logic                      rst,
  dmrfy_int8_pingpong_ctrl_if.slave bus
);

  ld_state_e                  ld_state_q;
  ex_state_e                  ex_state_q;
  logic [1:0]                 full_q;
  logic                       ld_ptr_q;
  logic                       ex_ptr_q;
  logic [LOAD_ADDR_WIDTH-1:0] load_depth_q;
  dmrfy_ex_cmd_t              ex_cmd_q;
  logic [EXEC_ADDR_WIDTH-1:0] addr_q;
  logic [REPEAT_WIDTH-1:0]    rep_q;
  logic                       err_q;

  logic ld_accept, ld_done, ex_accept, fire, addr_wrap, exec_last;

  assign ld_accept = bus.ld_cmd_valid & bus.ld_cmd_ready;
  assign ld_done   = (ld_state_q == L_ACTIVE) & bus.dmrfy_load_done;
  assign ex_accept = bus.ex_cmd_valid & bus.ex_cmd_ready;
  assign fire      = bus.exec_valid & bus.exec_ready;
  assign addr_wrap = (addr_q == ex_cmd_q.depth);
  assign exec_last = fire & addr_wrap & (rep_q == ex_cmd_q.reps);

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q   <= L_IDLE;
      ex_state_q   <= E_IDLE;
      full_q       <= 2'b00;
      ld_ptr_q     <= 1'b0;
      ex_ptr_q     <= 1'b0;
      load_depth_q <= '0;
      ex_cmd_q     <= '0;
      addr_q       <= '0;
      rep_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (ld_state_q)
        L_IDLE: begin
          if (ld_accept) begin
            load_depth_q <= bus.ld_cmd_depth;
            ld_state_q   <= L_ACTIVE;
          end
        end
        L_ACTIVE: begin
          if (bus.dmrfy_load_done) begin
            ld_ptr_q   <= ~ld_ptr_q;
            ld_state_q <= L_IDLE;
          end
        end
        default: ld_state_q <= L_IDLE;
      endcase

      if (bus.dmrfy_load_done && ld_state_q != L_ACTIVE) err_q <= 1'b1;

      unique case (ex_state_q)
        E_IDLE: begin
          if (ex_accept) begin
            ex_cmd_q   <= '{depth: bus.ex_cmd_depth, reps: bus.ex_cmd_repeat};
            addr_q     <= '0;
            rep_q      <= '0;
            ex_state_q <= E_WAIT;
          end
        end
        E_WAIT: begin
          if (full_q[ex_ptr_q]) ex_state_q <= E_RUN;
        end
        E_RUN: begin
          if (fire) begin
            if (addr_wrap) begin
              addr_q <= '0;
              if (exec_last) begin
                ex_ptr_q   <= ~ex_ptr_q;
                ex_state_q <= E_IDLE;
              end else begin
                rep_q <= rep_q + 1'b1;
              end
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: ex_state_q <= E_IDLE;
      endcase

      // Set and clear always target different bits: load only fills empty, exec only drains full.
      if (ld_done)   full_q[ld_ptr_q] <= 1'b1;
      if (exec_last) full_q[ex_ptr_q] <= 1'b0;
    end
  end

  assign bus.ld_cmd_ready        = (ld_state_q == L_IDLE) & ~full_q[ld_ptr_q];
  assign bus.dmrfy_load_active   = (ld_state_q == L_ACTIVE);
  assign bus.dmrfy_load_tile_sel = (ld_state_q == L_ACTIVE) & ld_ptr_q;
  assign bus.dmrfy_load_depth    = load_depth_q;
  assign bus.ex_cmd_ready        = (ex_state_q == E_IDLE);
  assign bus.exec_valid          = (ex_state_q == E_RUN);
  assign bus.dmrfy_exec_addr     = addr_q;
  assign bus.dmrfy_exec_tile_sel = ex_ptr_q;
  assign bus.tile_full           = full_q;
  assign bus.err_spurious_done   = err_q;

  fixed_lat_pipe #(
    .WIDTH(2),
    .DEPTH(EXEC_PIPE_LAT)
  ) u_data_pipe (
    .clk (clk),
    .rst (rst),
    .din ({fire, exec_last}),
    .dout({bus.exec_data_valid, bus.exec_data_last})
  );

endmodule
